blocpu_stream_loader: RTL and testbench

Loads a BloCPU program into blocpu_core instruction memory from a byte stream (UART receiver output) instead of a hardcoded sequence. It frames, assembles and checksums instructions of parametrised width. It drives the core's instruction-write interface and holds the core in reset during the load. It sends an ACK/NAK status byte and releases the core to run on request.

---
 rtl/blocpu_stream_loader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_blocpu_stream_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blocpu_stream_loader.sv
// Byte-stream program loader for blocpu_core: frames, assembles and checksums
// instruction words, holds the core in reset while loading and reports ACK/NAK.
module blocpu_stream_loader #(
    parameter int         INSTR_WIDTH    = 12,
    parameter int         ADDR_WIDTH     = 16,
    parameter int         DEPTH          = 4096,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   run_request,
    output logic                   core_reset,
    output logic                   core_running,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   instr_write,
    output logic                   loaded,
    output logic                   error,
    output logic [ADDR_WIDTH-1:0]  words_loaded
);
    localparam int NB = (INSTR_WIDTH + 7) / 8;
    localparam int AW = NB * 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CW = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [7:0]    ACK      = 8'h06;
    localparam logic [7:0]    NAK      = 8'h15;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CHECK, STATUS, READY, RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_hi_q, cnt_hi_d;
    logic [15:0]            n_q, n_d;
    logic [AW-1:0]          asm_q, asm_d;
    logic [7:0]             csum_q, csum_d;
    logic [2:0]             byte_idx_q, byte_idx_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             status_q, status_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   core_reset_q, core_reset_d;
    logic                   core_running_q, core_running_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0]  instr_addr_q, instr_addr_d;
    logic                   instr_write_q, instr_write_d;
    logic                   loaded_q, loaded_d;
    logic                   error_q, error_d;
    logic [ADDR_WIDTH-1:0]  words_loaded_q, words_loaded_d;

    logic [AW-1:0] asm_shift;
    logic [15:0]   n_full;
    logic          timed_out;
    logic          sync_seen;
    logic          in_frame;

    always_comb begin
        state_d        = state_q;
        cnt_hi_d       = cnt_hi_q;
        n_d            = n_q;
        asm_d          = asm_q;
        csum_d         = csum_q;
        byte_idx_d     = byte_idx_q;
        tmo_d          = tmo_q;
        status_d       = status_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        core_reset_d   = core_reset_q;
        core_running_d = core_running_q;
        instr_data_d   = instr_data_q;
        instr_addr_d   = instr_addr_q;
        instr_write_d  = 1'b0;
        loaded_d       = loaded_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;

        asm_shift = (asm_q << 8) | AW'(rx_data);
        n_full    = {cnt_hi_q, rx_data};
        in_frame  = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                    (state_q == DATA)   || (state_q == CHECK);
        sync_seen = rx_valid && (rx_data == SYNC_BYTE) &&
                    ((state_q == IDLE) || (state_q == RUN));

        // Idle-gap watchdog: any received byte restarts the count.
        timed_out = 1'b0;
        if (in_frame) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                timed_out = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                core_reset_d   = 1'b1;
                core_running_d = 1'b0;
            end
            CNT_HI: begin
                if (timed_out) begin
                    status_d = NAK;
                    error_d  = 1'b1;
                    state_d  = STATUS;
                end else if (rx_valid) begin
                    cnt_hi_d = rx_data;
                    state_d  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (timed_out) begin
                    status_d = NAK;
                    error_d  = 1'b1;
                    state_d  = STATUS;
                end else if (rx_valid) begin
                    n_d = n_full;
                    if ((n_full == 16'd0) || (CW'(n_full) > DEPTH_C)) begin
                        status_d = NAK;
                        error_d  = 1'b1;
                        state_d  = STATUS;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (timed_out) begin
                    status_d = NAK;
                    error_d  = 1'b1;
                    state_d  = STATUS;
                end else if (rx_valid) begin
                    asm_d  = asm_shift;
                    csum_d = csum_q ^ rx_data;
                    if (byte_idx_q == 3'(NB - 1)) begin
                        byte_idx_d     = '0;
                        instr_write_d  = 1'b1;
                        instr_addr_d   = words_loaded_q;
                        instr_data_d   = asm_shift[INSTR_WIDTH-1:0];
                        words_loaded_d = words_loaded_q + ADDR_WIDTH'(1);
                        if ((CW'(words_loaded_q) + CW'(1)) == CW'(n_q)) begin
                            state_d = CHECK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                if (timed_out) begin
                    status_d = NAK;
                    error_d  = 1'b1;
                    state_d  = STATUS;
                end else if (rx_valid) begin
                    state_d = STATUS;
                    if (rx_data == csum_q) begin
                        status_d = ACK;
                        loaded_d = 1'b1;
                    end else begin
                        status_d = NAK;
                        error_d  = 1'b1;
                    end
                end
            end
            STATUS: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = status_q;
                    state_d    = loaded_q ? READY : IDLE;
                end
            end
            READY: begin
                core_reset_d   = 1'b1;
                core_running_d = 1'b0;
                if (run_request) begin
                    core_reset_d   = 1'b0;
                    core_running_d = 1'b1;
                    state_d        = RUN;
                end
            end
            RUN: begin
                core_reset_d   = 1'b0;
                core_running_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A new frame may start from idle or as a reload of a running core.
        if (sync_seen) begin
            state_d        = CNT_HI;
            loaded_d       = 1'b0;
            error_d        = 1'b0;
            words_loaded_d = '0;
            csum_d         = '0;
            byte_idx_d     = '0;
            tmo_d          = '0;
            core_reset_d   = 1'b1;
            core_running_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_hi_q       <= '0;
            n_q            <= '0;
            asm_q          <= '0;
            csum_q         <= '0;
            byte_idx_q     <= '0;
            tmo_q          <= '0;
            status_q       <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            core_reset_q   <= 1'b1;
            core_running_q <= 1'b0;
            instr_data_q   <= '0;
            instr_addr_q   <= '0;
            instr_write_q  <= 1'b0;
            loaded_q       <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_hi_q       <= cnt_hi_d;
            n_q            <= n_d;
            asm_q          <= asm_d;
            csum_q         <= csum_d;
            byte_idx_q     <= byte_idx_d;
            tmo_q          <= tmo_d;
            status_q       <= status_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            core_reset_q   <= core_reset_d;
            core_running_q <= core_running_d;
            instr_data_q   <= instr_data_d;
            instr_addr_q   <= instr_addr_d;
            instr_write_q  <= instr_write_d;
            loaded_q       <= loaded_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign core_reset   = core_reset_q;
    assign core_running = core_running_q;
    assign instr_data   = instr_data_q;
    assign instr_addr   = instr_addr_q;
    assign instr_write  = instr_write_q;
    assign loaded       = loaded_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_blocpu_stream_loader.sv
// Bench for blocpu_stream_loader: frame-level vector table, hand-written corner
// sequences (run/reload, timeout with tx_busy, mid-frame reset) and random frames.
module tb_blocpu_stream_loader;
    localparam int IW    = 12;
    localparam int AWD   = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            tx_busy;
    logic            run_request;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            core_reset;
    logic            core_running;
    logic [IW-1:0]   instr_data;
    logic [AWD-1:0]  instr_addr;
    logic            instr_write;
    logic            loaded;
    logic            error;
    logic [AWD-1:0]  words_loaded;

    blocpu_stream_loader #(
        .INSTR_WIDTH(IW), .ADDR_WIDTH(AWD), .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .run_request(run_request), .core_reset(core_reset),
        .core_running(core_running), .instr_data(instr_data),
        .instr_addr(instr_addr), .instr_write(instr_write), .loaded(loaded),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [27:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    logic [15:0] frame_words[$];
    logic [11:0] exp_d_q[$];
    int          word_end_q[$];
    int          last_edge;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(negedge clk) begin
        if (instr_write === 1'b1) begin
            wr_q.push_back({instr_addr, instr_data});
            wr_cyc_q.push_back(cyc);
        end
        if (tx_start === 1'b1) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
    end

    typedef struct {
        logic [15:0]       n;
        int                nsend;
        logic [2:0][15:0]  raw;
        logic [7:0]        csum;
        int                nw_exp;
        logic [2:0][11:0]  d_exp;
        logic [7:0]        st_exp;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wr_q.delete(); wr_cyc_q.delete(); tx_q.delete(); tx_cyc_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        last_edge = cyc;
        rx_valid  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input bit with_sync, input logic [15:0] n,
                              input logic [7:0] cs, input int gmax);
        word_end_q.delete();
        if (with_sync) send_byte(8'hA5, $urandom_range(1, gmax));
        send_byte(n[15:8], $urandom_range(1, gmax));
        send_byte(n[7:0], $urandom_range(1, gmax));
        if (n != 16'd0 && n <= DEPTH) begin
            foreach (frame_words[i]) begin
                send_byte(frame_words[i][15:8], $urandom_range(1, gmax));
                send_byte(frame_words[i][7:0], $urandom_range(1, gmax));
                word_end_q.push_back(last_edge);
            end
            send_byte(cs, $urandom_range(1, gmax));
        end
    endtask

    task automatic wait_tx(input string nm);
        int k = 0;
        while (tx_q.size() == 0 && k < 300) begin
            tick();
            k++;
        end
        check({nm, "_tx_seen"}, (tx_q.size() != 0), 1);
    endtask

    task automatic verify(input string nm, input logic [7:0] st, input int nw);
        if (tx_q.size() > 0) begin
            check({nm, "_status"}, tx_q[0], st);
            check({nm, "_tx_lat"}, tx_cyc_q[0] - last_edge, 1);
        end
        check({nm, "_tx_count"}, tx_q.size(), 1);
        check({nm, "_nwrites"}, wr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", nm, i), wr_q[i][27:12], i);
            check($sformatf("%s_data%0d", nm, i), wr_q[i][11:0], exp_d_q[i]);
            check($sformatf("%s_wlat%0d", nm, i), wr_cyc_q[i], word_end_q[i]);
        end
        check({nm, "_loaded"}, loaded, (st == 8'h06));
        check({nm, "_error"}, error, (st == 8'h15));
        check({nm, "_words"}, words_loaded, nw);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_core_reset"}, core_reset, 1);
        check({nm, "_core_running"}, core_running, 0);
        check({nm, "_instr_write"}, instr_write, 0);
        check({nm, "_instr_data"}, instr_data, 0);
        check({nm, "_instr_addr"}, instr_addr, 0);
        check({nm, "_tx_start"}, tx_start, 0);
        check({nm, "_tx_data"}, tx_data, 0);
        check({nm, "_loaded"}, loaded, 0);
        check({nm, "_error"}, error, 0);
        check({nm, "_words"}, words_loaded, 0);
    endtask

    task automatic load_test1_words();
        frame_words.delete(); exp_d_q.delete();
        frame_words.push_back(16'h0800); exp_d_q.push_back(12'h800);
        frame_words.push_back(16'h0940); exp_d_q.push_back(12'h940);
        frame_words.push_back(16'h0B09); exp_d_q.push_back(12'hB09);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] n;
        logic [15:0] w;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [7:0]  st;
        bit          valid;
        int          kind;
        int          e0;
        int          k;

        tbl[0] = '{16'd3, 3, {16'h0B09, 16'h0940, 16'h0800}, 8'h43, 3, {12'hB09, 12'h940, 12'h800}, 8'h06};
        tbl[1] = '{16'd3, 3, {16'h0B09, 16'h0940, 16'h0800}, 8'h44, 3, {12'hB09, 12'h940, 12'h800}, 8'h15};
        tbl[2] = '{16'd0, 0, {16'h0, 16'h0, 16'h0}, 8'h00, 0, {12'h0, 12'h0, 12'h0}, 8'h15};
        tbl[3] = '{16'd9, 0, {16'h0, 16'h0, 16'h0}, 8'h00, 0, {12'h0, 12'h0, 12'h0}, 8'h15};
        tbl[4] = '{16'd1, 1, {16'h0, 16'h0, 16'hF123}, 8'hD2, 1, {12'h0, 12'h0, 12'h123}, 8'h06};
        tbl[5] = '{16'd2, 2, {16'h0, 16'hA000, 16'h0FFF}, 8'h50, 2, {12'h0, 12'h000, 12'hFFF}, 8'h06};

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; run_request = 1'b0;
        repeat (2) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        for (int t = 0; t < 6; t++) begin
            frame_words.delete(); exp_d_q.delete();
            for (int i = 0; i < tbl[t].nsend; i++) begin
                frame_words.push_back(tbl[t].raw[i]);
                exp_d_q.push_back(tbl[t].d_exp[i]);
            end
            clear_q();
            send_frame(1'b1, tbl[t].n, tbl[t].csum, 3);
            wait_tx($sformatf("vec%0d", t));
            verify($sformatf("vec%0d", t), tbl[t].st_exp, tbl[t].nw_exp);
            repeat (3) tick();
            check($sformatf("vec%0d_hold_rst", t), core_reset, 1);
            check($sformatf("vec%0d_hold_run", t), core_running, 0);
            run_request = 1'b1;
            tick();
            run_request = 1'b0;
            check($sformatf("vec%0d_run_rst", t), core_reset, (tbl[t].st_exp == 8'h06) ? 0 : 1);
            check($sformatf("vec%0d_run_run", t), core_running, (tbl[t].st_exp == 8'h06) ? 1 : 0);
            repeat (2) tick();
        end

        // Reload from RUN: junk byte ignored, sync drops the core back into reset.
        load_test1_words();
        clear_q();
        send_byte(8'h00, 2);
        check("reload_junk_run", core_running, 1);
        check("reload_junk_rst", core_reset, 0);
        send_byte(8'hA5, 0);
        check("reload_sync_run", core_running, 0);
        check("reload_sync_rst", core_reset, 1);
        tick();
        send_frame(1'b0, 16'd3, 8'h43, 2);
        wait_tx("reload");
        verify("reload", 8'h06, 3);
        run_request = 1'b1; tick(); run_request = 1'b0;

        // Idle-gap timeout mid-word, with the transmitter busy when it fires.
        clear_q();
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_byte(8'h08, 0);
        tx_busy = 1'b1;
        e0 = last_edge;
        k = 0;
        while (error !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check("tmo_delay", cyc - e0, TMO);
        repeat (10) tick();
        check("tmo_busy_hold", tx_q.size(), 0);
        tx_busy = 1'b0;
        e0 = cyc + 1;
        wait_tx("tmo");
        if (tx_q.size() > 0) begin
            check("tmo_status", tx_q[0], 8'h15);
            check("tmo_tx_edge", tx_cyc_q[0], e0);
        end
        check("tmo_nwrites", wr_q.size(), 0);
        check("tmo_loaded", loaded, 0);
        check("tmo_error", error, 1);

        // Synchronous reset in the middle of DATA, then a clean reload from addr 0.
        clear_q();
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_byte(8'h08, 1);
        send_byte(8'h00, 1);
        send_byte(8'h09, 1);
        check("midrst_prewrites", wr_q.size(), 1);
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        tick();
        load_test1_words();
        clear_q();
        send_frame(1'b1, 16'd3, 8'h43, 2);
        wait_tx("postrst");
        verify("postrst", 8'h06, 3);
        run_request = 1'b1; tick(); run_request = 1'b0;

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (it == 0) n = 16'(DEPTH);
            else if (kind == 0) n = 16'd0;
            else if (kind == 1) n = 16'(DEPTH + 1 + $urandom_range(0, 200));
            else n = 16'($urandom_range(1, DEPTH));
            valid = (n >= 1) && (n <= DEPTH);
            frame_words.delete(); exp_d_q.delete();
            cs = 8'h00;
            if (valid) begin
                for (int i = 0; i < n; i++) begin
                    w = 16'($urandom);
                    frame_words.push_back(w);
                    exp_d_q.push_back(w[11:0]);
                    cs = cs ^ w[15:8] ^ w[7:0];
                end
            end
            st = 8'h06;
            if ($urandom_range(0, 3) == 0) begin
                cs = cs ^ 8'($urandom_range(1, 255));
                st = 8'h15;
            end
            if (!valid) st = 8'h15;
            clear_q();
            for (int j = 0; j < $urandom_range(0, 3); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1);
            end
            send_frame(1'b1, n, cs, 4);
            wait_tx($sformatf("rnd%0d", it));
            verify($sformatf("rnd%0d", it), st, valid ? int'(n) : 0);
            if (st == 8'h06) begin
                run_request = 1'b1; tick(); run_request = 1'b0;
                check($sformatf("rnd%0d_running", it), core_running, 1);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
